// File: rtl/mac_pkg.sv
// Shared definitions for the 8-bit multiply-accumulate block: FSM state
// encoding and default parameter values.
package mac_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int N_TERMS_DEF = 8;
    localparam int ACC_W_DEF   = 24;

endpackage

// File: rtl/mac_8_array.sv
// Combinational 8x8 unsigned array multiplier: one row of partial products
// per multiplier bit, summed row by row.
module array_8 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] product
);

    logic [15:0] rows [8];
    logic [15:0] partial [9];

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            rows[i] = b[i] ? ({8'b0, a} << i) : 16'd0;
        end
        partial[0] = 16'd0;
        for (int i = 0; i < 8; i++) begin
            partial[i + 1] = partial[i] + rows[i];
        end
        product = partial[8];
    end

endmodule

// File: rtl/mac_8.sv
// Multiply-accumulate: streams unsigned 8-bit operand pairs, accumulates
// their products, and hands back sum, pair count and a sticky overflow flag.
module mac_8
    import mac_pkg::*;
#(
    parameter int N_TERMS = N_TERMS_DEF,
    parameter int ACC_W   = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [7:0]       count,
    output logic             overflow
);

    localparam logic [7:0] LAST_COUNT = 8'(N_TERMS - 1);

    state_t      state;
    logic [15:0] product;
    logic [15:0] prod_q;
    logic        prod_valid;
    logic [ACC_W:0] sum;
    logic        in_beat;
    logic        last_beat;

    array_8 u_mult (
        .a       (a),
        .b       (b),
        .product (product)
    );

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);
    assign in_beat   = in_valid && in_ready;
    assign last_beat = in_beat && (in_last || (count == LAST_COUNT));

    // One extra bit on the add exposes the carry out of the accumulator.
    assign sum = {1'b0, acc_out} + {{(ACC_W - 15){1'b0}}, prod_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ACCUM;
            prod_q     <= 16'd0;
            prod_valid <= 1'b0;
            acc_out    <= '0;
            count      <= 8'd0;
            overflow   <= 1'b0;
        end else begin
            prod_valid <= in_beat;
            if (in_beat) begin
                prod_q <= product;
            end
            if (prod_valid) begin
                acc_out <= sum[ACC_W-1:0];
                if (sum[ACC_W]) begin
                    overflow <= 1'b1;
                end
            end

            case (state)
                ACCUM: begin
                    if (in_beat) begin
                        count <= count + 8'd1;
                    end
                    if (last_beat) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    state <= HOLD;
                end
                HOLD: begin
                    // The final product landed on entry to HOLD, so clearing here cannot race an add.
                    if (out_ready) begin
                        state    <= ACCUM;
                        acc_out  <= '0;
                        count    <= 8'd0;
                        overflow <= 1'b0;
                    end
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_8.sv
// Scoreboard bench for mac_8: three instances (default, N_TERMS=4, ACC_W=16)
// share operand/handshake inputs; a monitor pops expected results on each output beat.
module tb_mac_8;

    typedef struct {
        int          id;
        logic [31:0] acc;
        logic [7:0]  cnt;
        logic        ovf;
    } result_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  a = 8'd0;
    logic [7:0]  b = 8'd0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_valid0 = 1'b0, in_valid1 = 1'b0, in_valid2 = 1'b0;
    logic        in_ready0, in_ready1, in_ready2;
    logic        out_valid0, out_valid1, out_valid2;
    logic [23:0] acc0, acc1;
    logic [15:0] acc2;
    logic [7:0]  count0, count1, count2;
    logic        overflow0, overflow1, overflow2;

    result_t exp_q[$];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mac_8 #(.N_TERMS(8), .ACC_W(24)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
        .a(a), .b(b), .in_last(in_last), .out_valid(out_valid0), .out_ready(out_ready),
        .acc_out(acc0), .count(count0), .overflow(overflow0)
    );

    mac_8 #(.N_TERMS(4), .ACC_W(24)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a), .b(b), .in_last(in_last), .out_valid(out_valid1), .out_ready(out_ready),
        .acc_out(acc1), .count(count1), .overflow(overflow1)
    );

    mac_8 #(.N_TERMS(8), .ACC_W(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a), .b(b), .in_last(in_last), .out_valid(out_valid2), .out_ready(out_ready),
        .acc_out(acc2), .count(count2), .overflow(overflow2)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic pushExpected(input int id, input logic [31:0] acc, input logic [7:0] cnt, input logic ovf);
        result_t r;
        r.id = id; r.acc = acc; r.cnt = cnt; r.ovf = ovf;
        exp_q.push_back(r);
    endtask

    task automatic checkOutput(input int id, input logic [31:0] acc, input logic [7:0] cnt, input logic ovf);
        result_t r;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_result: dut%0d presented acc=%0d count=%0d with nothing expected", id, acc, cnt);
        end else begin
            r = exp_q.pop_front();
            check($sformatf("result_dut_id"), id, r.id);
            check($sformatf("dut%0d_acc_out", id), acc, r.acc);
            check($sformatf("dut%0d_count", id), {24'd0, cnt}, {24'd0, r.cnt});
            check($sformatf("dut%0d_overflow", id), {31'd0, ovf}, {31'd0, r.ovf});
        end
    endtask

    // Monitor: compare every output beat of any instance against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && out_ready) begin
            if (out_valid0) checkOutput(0, {8'd0, acc0}, count0, overflow0);
            if (out_valid1) checkOutput(1, {8'd0, acc1}, count1, overflow1);
            if (out_valid2) checkOutput(2, {16'd0, acc2}, count2, overflow2);
        end
    end

    function automatic logic readyOf(input int id);
        case (id)
            0: return in_ready0;
            1: return in_ready1;
            default: return in_ready2;
        endcase
    endfunction

    function automatic logic validOf(input int id);
        case (id)
            0: return out_valid0;
            1: return out_valid1;
            default: return out_valid2;
        endcase
    endfunction

    task automatic setValid(input int id, input logic v);
        case (id)
            0: in_valid0 = v;
            1: in_valid1 = v;
            default: in_valid2 = v;
        endcase
    endtask

    // Issue one operand pair; returns 1 time unit after the accepting edge.
    task automatic applyStimulus(input int id, input logic [7:0] av, input logic [7:0] bv, input logic last);
        int waited;
        waited = 0;
        a = av; b = bv; in_last = last;
        setValid(id, 1'b1);
        @(negedge clk);
        while (!readyOf(id) && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!readyOf(id)) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout: dut%0d in_ready stayed 0, expected 1", id);
        end
        @(posedge clk);
        #1;
        setValid(id, 1'b0);
        a = 8'hA5; b = 8'h5A; in_last = 1'b1;
    endtask

    task automatic waitValid(input int id);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!validOf(id) && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!validOf(id)) begin
            checks++;
            failures++;
            $display("[TB] FAIL result_timeout: dut%0d out_valid stayed 0, expected 1", id);
        end
    endtask

    task automatic waitResult(input int id);
        waitValid(id);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", {31'd0, out_valid0}, 32'd0);
        check("reset_acc", {8'd0, acc0}, 32'd0);
        check("reset_count", {24'd0, count0}, 32'd0);
        check("reset_overflow", {31'd0, overflow0}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("after_reset_in_ready", {31'd0, in_ready0}, 32'd1);

        // Single pair 3*5 with latency check
        pushExpected(0, 32'd15, 8'd1, 1'b0);
        applyStimulus(0, 8'd3, 8'd5, 1'b1);
        check("latency_not_early", {31'd0, out_valid0}, 32'd0);
        check("latency_in_ready_low", {31'd0, in_ready0}, 32'd0);
        @(posedge clk);
        #1;
        check("latency_valid", {31'd0, out_valid0}, 32'd1);
        @(posedge clk);
        #1;
        check("single_cleared", {31'd0, out_valid0}, 32'd0);
        check("single_in_ready", {31'd0, in_ready0}, 32'd1);

        // Eight full-scale products back to back
        pushExpected(0, 32'd520200, 8'd8, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(0, 8'd255, 8'd255, (i == 7));
        waitResult(0);

        // Zero product still counted; idle garbage between beats ignored
        pushExpected(0, 32'd16, 8'd3, 1'b0);
        applyStimulus(0, 8'd0, 8'd7, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("idle_count", {24'd0, count0}, 32'd1);
        applyStimulus(0, 8'd4, 8'd4, 1'b0);
        applyStimulus(0, 8'd9, 8'd0, 1'b1);
        waitResult(0);

        // N_TERMS=4: forced last, fifth pair blocked until output beat
        out_ready = 1'b0;
        pushExpected(1, 32'd4, 8'd4, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 8'd1, 8'd1, 1'b0);
        a = 8'd1; b = 8'd1; in_last = 1'b0;
        in_valid1 = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("n4_fifth_blocked", {31'd0, in_ready1}, 32'd0);
        end
        check("n4_holding", {31'd0, out_valid1}, 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        applyStimulus(1, 8'd1, 8'd1, 1'b0);
        check("n4_fifth_count", {24'd0, count1}, 32'd1);
        pushExpected(1, 32'd2, 8'd2, 1'b0);
        applyStimulus(1, 8'd1, 8'd1, 1'b1);
        waitResult(1);

        // ACC_W=16 overflow, then clean restart
        pushExpected(2, 32'd64514, 8'd2, 1'b1);
        applyStimulus(2, 8'd255, 8'd255, 1'b0);
        applyStimulus(2, 8'd255, 8'd255, 1'b1);
        waitResult(2);
        pushExpected(2, 32'd6, 8'd1, 1'b0);
        applyStimulus(2, 8'd2, 8'd3, 1'b1);
        waitResult(2);

        // Backpressure: hold for 10 cycles, then release
        out_ready = 1'b0;
        pushExpected(0, 32'd63, 8'd1, 1'b0);
        applyStimulus(0, 8'd7, 8'd9, 1'b1);
        waitValid(0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_acc", {8'd0, acc0}, 32'd63);
            check("hold_count", {24'd0, count0}, 32'd1);
            check("hold_in_ready", {31'd0, in_ready0}, 32'd0);
            check("hold_out_valid", {31'd0, out_valid0}, 32'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_out_valid", {31'd0, out_valid0}, 32'd0);
        check("release_in_ready", {31'd0, in_ready0}, 32'd1);
        check("release_acc", {8'd0, acc0}, 32'd0);
        check("release_count", {24'd0, count0}, 32'd0);

        // Reset one cycle after an input beat discards the product
        applyStimulus(0, 8'd10, 8'd10, 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_reset_out_valid", {31'd0, out_valid0}, 32'd0);
            check("post_reset_acc", {8'd0, acc0}, 32'd0);
            check("post_reset_count", {24'd0, count0}, 32'd0);
        end
        check("post_reset_in_ready", {31'd0, in_ready0}, 32'd1);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL leftover_results: %0d pending, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
